mdu_sequencer: RTL and testbench

//  Sequences the shared multiply/divide unit in the execute stage and

---
 rtl/mdu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: MUL in MULT_LAT+1 cycles, DIV in DIV_ITER+1 cycles, pipeline held via stall_o.
// Optional MDU_DIVZERO_FLAG_EN adds divzero_o and a one-cycle divide-by-zero shortcut.
module mdu_sequencer #(
  parameter int MULT_LAT = 4,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic        signed_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        cancel,
  output logic        stall_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [1:0]  hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef MDU_DIVZERO_FLAG_EN
 ,output logic        divzero_o
`endif
);

  localparam int CNT_MAX = (MULT_LAT > DIV_ITER) ? MULT_LAT : DIV_ITER;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        opa_q, opa_d, opb_q, opb_d;
  logic               sgn_q, sgn_d;
  logic [31:0]        rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               valid_q, valid_d;
`ifdef MDU_DIVZERO_FLAG_EN
  logic               dz_q, dz_d;
`endif

  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] shifted, trial;
  logic [31:0] rem_n, quo_n, q_fix, r_fix;
  logic        neg_quo, neg_rem;

  always_comb begin
    mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
    mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
    prod  = mul_a * mul_b;
  end

  // One restoring step: bring in the next dividend bit, keep the subtraction if it did not borrow.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[32]) begin
      rem_n = trial[31:0];
      quo_n = {quo_q[30:0], 1'b1};
    end else begin
      rem_n = shifted[31:0];
      quo_n = {quo_q[30:0], 1'b0};
    end
    neg_quo = sgn_q & (opa_q[31] ^ opb_q[31]);
    neg_rem = sgn_q & opa_q[31];
    q_fix   = neg_quo ? (32'd0 - quo_n) : quo_n;
    r_fix   = neg_rem ? (32'd0 - rem_n) : rem_n;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
    dz_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!cancel && (div_start || mult_start)) begin
          opa_d   = opa;
          opb_d   = opb;
          sgn_d   = signed_op;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (signed_op && opa[31]) ? (32'd0 - opa) : opa;
          dvs_d   = (signed_op && opb[31]) ? (32'd0 - opb) : opb;
          state_d = div_start ? DIV : MUL;
`ifdef MDU_DIVZERO_FLAG_EN
          if (div_start && opb == 32'd0) begin
            state_d = DONE;
            hi_d    = opa;
            lo_d    = 32'hFFFF_FFFF;
            valid_d = 1'b1;
            dz_d    = 1'b1;
          end
`endif
        end
      end
      MUL: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MULT_LAT - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            valid_d = 1'b1;
            if (dvs_q == 32'd0) begin
              hi_d = opa_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = r_fix;
              lo_d = q_fix;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
`ifdef MDU_DIVZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // Stall must rise in the start cycle itself, before the state register moves.
  assign stall_o   = ((state_q == IDLE) && (mult_start || div_start) && !cancel) ||
                     (state_q == MUL) || (state_q == DIV);
  assign busy_o    = (state_q == MUL) || (state_q == DIV);
  assign valid_o   = valid_q;
  assign hilo_we_o = {2{valid_q}};
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
  assign divzero_o = dz_q;
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: driver pushes expected {hi,lo,cycle} into a queue, a negedge monitor pops on valid_o.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mult_start = 1'b0, div_start = 1'b0, signed_op = 1'b0, cancel = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic        stall_o, busy_o, valid_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] hi_o, lo_o;
`ifdef MDU_DIVZERO_FLAG_EN
  logic        divzero_o;
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  mdu_sequencer #(.MULT_LAT(4), .DIV_ITER(32)) dut (
    .clk(clk), .rst(rst),
    .mult_start(mult_start), .div_start(div_start), .signed_op(signed_op),
    .opa(opa), .opb(opb), .cancel(cancel),
    .stall_o(stall_o), .busy_o(busy_o), .valid_o(valid_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
`ifdef MDU_DIVZERO_FLAG_EN
   ,.divzero_o(divzero_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    logic        dz;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(valid_o), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", 64'(cyc), 64'(e.cyc));
        chk("hi", 64'(hi_o), 64'(e.hi));
        chk("lo", 64'(lo_o), 64'(e.lo));
        chk("hilo_we", 64'(hilo_we_o), 64'd3);
        chk("busy_done", 64'(busy_o), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        chk("divzero", 64'(divzero_o), 64'(e.dz));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_starts();
    mult_start = 1'b0;
    div_start  = 1'b0;
  endtask

  // Issue one operation in the current cycle and step through to one cycle past DONE.
  task automatic run_op(input string name, input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input logic edz);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cyc = cyc + lat; e.dz = edz;
    q.push_back(e);
    mult_start = m; div_start = d; signed_op = s; opa = a; opb = b;
    for (int i = 0; i <= lat; i++) begin
      #1;
      chk({name, "_stall"}, 64'(stall_o), (i < lat) ? 64'd1 : 64'd0);
      tick();
      if (i == 0) clear_starts();
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_we",    64'(hilo_we_o), 64'd0);
    chk("rst_hi",    64'(hi_o), 64'd0);
    chk("rst_lo",    64'(lo_o), 64'd0);
    rst = 1'b0;
    tick();

    // Multiplies
    run_op("multu_ffff_x2", 1, 0, 0, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5, 0);
    run_op("mult_m1_m1",    1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5, 0);
    run_op("multu_m1_m1",   1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 0);
    run_op("mult_m3_5",     1, 0, 1, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 0);

    // Divides
    run_op("div_m7_2",      0, 1, 1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    run_op("div_7_m2",      0, 1, 1, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 0);
    run_op("div_min_m1",    0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0);
    run_op("divu_5_0",      0, 1, 0, 32'h5, 32'h0, 32'h00000005, 32'hFFFFFFFF, DZ_LAT, 1);
    run_op("div_m7_0",      0, 1, 1, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, DZ_LAT, 1);
    run_op("divu_100_7",    0, 1, 0, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 33, 0);

    // Cancel mid-divide: no valid pulse, previous result retained.
    c0 = cyc;
    div_start = 1'b1; signed_op = 1'b0; opa = 32'd1000; opb = 32'd3;
    tick();
    clear_starts();
    while (cyc < c0 + 10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_stall", 64'(stall_o), 64'd0);
    chk("cancel_busy",  64'(busy_o), 64'd0);
    chk("cancel_hi",    64'(hi_o), 64'h2);
    chk("cancel_lo",    64'(lo_o), 64'hE);
    repeat (30) tick();

    // Cancel in IDLE suppresses the start.
    mult_start = 1'b1; cancel = 1'b1;
    #1 chk("idle_cancel_stall", 64'(stall_o), 64'd0);
    tick();
    clear_starts(); cancel = 1'b0;
    chk("idle_cancel_busy", 64'(busy_o), 64'd0);
    repeat (8) tick();

    // Both starts high and held through DONE: divide wins, exactly one result.
    begin
      exp_t e;
      e.hi = 32'h2; e.lo = 32'hE; e.cyc = cyc + 33; e.dz = 1'b0;
      q.push_back(e);
    end
    c0 = cyc;
    mult_start = 1'b1; div_start = 1'b1; signed_op = 1'b0; opa = 32'd100; opb = 32'd7;
    while (cyc < c0 + 33) tick();
    #1 chk("done_stall_held", 64'(stall_o), 64'd0);
    tick();
    clear_starts();
    tick();
    chk("held_busy_after", 64'(busy_o), 64'd0);
    repeat (6) tick();

    // Reset in the middle of a divide.
    c0 = cyc;
    div_start = 1'b1; signed_op = 1'b0; opa = 32'd77; opb = 32'd5;
    tick();
    clear_starts();
    while (cyc < c0 + 15) tick();
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_busy",  64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_hi",    64'(hi_o), 64'd0);
    chk("midrst_lo",    64'(lo_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("mult_after_rst", 1, 0, 1, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 0);

    repeat (40) tick();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
